// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared op encodings, FSM states and iteration constants
// Rev 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/muldiv_negate.sv
// ============================================================================
// muldiv_negate : 32-bit conditional two's-complement negator
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_negate (
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] dout
);
    assign dout = en ? (~din + 32'd1) : din;
endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative 32-cycle multiply/divide unit with HI/LO registers
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_t             r_state, w_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_mb, r_ph, r_pl;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sa, r_sb;

    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_neg_hi, w_neg_lo;
    logic [WIDTH:0]     w_sum, w_shift;
    logic [WIDTH-1:0]   w_diff, w_res_hi, w_res_lo;
    logic               w_ge, w_is_div, w_neg_p, w_dz;

    // Operand magnitudes are taken straight from the inputs on the start edge.
    muldiv_negate u_mag_a (.en(~op[0] & a[31]), .din(a), .dout(w_mag_a));
    muldiv_negate u_mag_b (.en(~op[0] & b[31]), .din(b), .dout(w_mag_b));

    assign w_is_div = r_op[1];
    assign w_neg_p  = r_sa ^ r_sb;
    assign w_dz     = w_is_div && (r_mb == '0);

    muldiv_negate u_fix_lo (.en(w_neg_p), .din(r_pl), .dout(w_neg_lo));
    muldiv_negate u_fix_hi (.en(w_is_div ? r_sa : w_neg_p), .din(r_ph), .dout(w_neg_hi));

    assign w_sum   = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_mb} : '0);
    assign w_shift = {r_ph, r_pl[WIDTH-1]};
    assign w_ge    = w_shift >= {1'b0, r_mb};
    assign w_diff  = w_shift[WIDTH-1:0] - r_mb;

    // 64-bit negate of {hi,lo}: the borrow reaches hi only when lo is zero.
    always_comb begin
        w_res_lo = w_neg_lo;
        w_res_hi = w_neg_hi;
        if (w_dz) begin
            w_res_lo = '1;
            w_res_hi = r_a;
        end else if (!w_is_div && w_neg_p && (r_pl != '0)) begin
            w_res_hi = ~r_ph;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_mb     <= '0;
            r_ph     <= '0;
            r_pl     <= '0;
            r_cnt    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_a   <= a;
                        r_sa  <= ~op[0] & a[31];
                        r_sb  <= ~op[0] & b[31];
                        r_cnt <= CNT_W'(ITER - 1);
                        r_ph  <= '0;
                        // Divide keeps the divisor in r_mb; multiply keeps the multiplicand.
                        r_mb  <= op[1] ? w_mag_b : w_mag_a;
                        r_pl  <= op[1] ? w_mag_a : w_mag_b;
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (w_is_div) begin
                        r_ph <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        r_pl <= {r_pl[WIDTH-2:0], w_ge};
                    end else begin
                        r_ph <= w_sum[WIDTH:1];
                        r_pl <= {w_sum[0], r_pl[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    hi       <= w_res_hi;
                    lo       <= w_res_lo;
                    done     <= 1'b1;
                    div_zero <= w_dz;
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire
